// File: rtl/synth_param_rx_pkg.sv
// ----------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the synth-domain parameter receiver:
//   - rx_state_e        : handshake FSM states
//   - SYNTH_FCW_W       : default frequency-control-word width
//   - SYNTH_SHIFT_W     : default mod/synth shift field width
//   - synth_param_t     : parameter bundle at default widths (single voice)
// ----------------------------------------------------------------------------
package synth_pkg;

   localparam int unsigned SYNTH_FCW_W   = 24;
   localparam int unsigned SYNTH_SHIFT_W = 5;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      APPLY,
      WAIT_LOW
   } rx_state_e;

   typedef struct packed {
      logic [SYNTH_FCW_W-1:0]   carrier_fcws;
      logic [SYNTH_FCW_W-1:0]   mod_fcw;
      logic [SYNTH_SHIFT_W-1:0] mod_shift;
      logic                     note_en;
      logic [SYNTH_SHIFT_W-1:0] synth_shift;
   } synth_param_t;

endpackage

// File: rtl/synth_param_rx_sync.sv
// ----------------------------------------------------------------------------
// synchronizer
// Multi-flop synchronizer for signals crossing into the clk domain.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage
//   d_i   : asynchronous input
//   q_o   : synchronized output (last stage)
// STAGES must be 2 or more.
// ----------------------------------------------------------------------------
module synchronizer #(
   parameter int unsigned STAGES = 2,
   parameter int unsigned WIDTH  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [STAGES-1:0][WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/synth_param_rx.sv
// ----------------------------------------------------------------------------
// synth_param_rx
// Synth-domain end of the four-phase req/ack parameter handshake. Synchronizes
// req_in, captures the cpu_* buses into a shadow bundle, applies the bundle to
// the outputs in one edge (with an update pulse) and returns a flop-driven ack.
//
// Ports:
//   clk, rst_n          : pwm_clk, asynchronous active-low reset
//   req_in              : CPU-domain request (asynchronous)
//   cpu_carrier_fcws,
//   cpu_mod_fcw, cpu_mod_shift,
//   cpu_note_en,
//   cpu_synth_shift     : parameter buses, stable while req_in/ack_out high
//   sample_tick         : sample-boundary strobe (alignment build only)
//   ack_out             : registered acknowledge to the CPU domain
//   carrier_fcws, mod_fcw, mod_shift, note_en, synth_shift : applied parameters
//   update              : one-cycle pulse coinciding with new output values
//
// Build option: SYNTH_PARAM_RX_SAMPLE_ALIGN_EN delays the apply edge until
// sample_tick is high. Undefined: apply is unconditional, sample_tick ignored.
// ----------------------------------------------------------------------------
module synth_param_rx
   import synth_pkg::*;
#(
   parameter int unsigned N_VOICES    = 1,
   parameter int unsigned FCW_W       = SYNTH_FCW_W,
   parameter int unsigned SHIFT_W     = SYNTH_SHIFT_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_in,
   input  logic [N_VOICES*FCW_W-1:0] cpu_carrier_fcws,
   input  logic [FCW_W-1:0]          cpu_mod_fcw,
   input  logic [SHIFT_W-1:0]        cpu_mod_shift,
   input  logic [N_VOICES-1:0]       cpu_note_en,
   input  logic [SHIFT_W-1:0]        cpu_synth_shift,
   input  logic                      sample_tick,
   output logic                      ack_out,
   output logic [N_VOICES*FCW_W-1:0] carrier_fcws,
   output logic [FCW_W-1:0]          mod_fcw,
   output logic [SHIFT_W-1:0]        mod_shift,
   output logic [N_VOICES-1:0]       note_en,
   output logic [SHIFT_W-1:0]        synth_shift,
   output logic                      update
);

   typedef struct packed {
      logic [N_VOICES*FCW_W-1:0] carrier_fcws;
      logic [FCW_W-1:0]          mod_fcw;
      logic [SHIFT_W-1:0]        mod_shift;
      logic [N_VOICES-1:0]       note_en;
      logic [SHIFT_W-1:0]        synth_shift;
   } param_bundle_t;

   rx_state_e     state_q;
   param_bundle_t shadow_q;
   param_bundle_t out_q;
   param_bundle_t cpu_bundle;
   logic          update_q;
   logic          ack_q;
   logic          req_s;
   logic          apply_ok;

   synchronizer #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (1)
   ) u_req_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (req_in),
      .q_o   (req_s)
   );

   assign cpu_bundle = '{
      carrier_fcws: cpu_carrier_fcws,
      mod_fcw:      cpu_mod_fcw,
      mod_shift:    cpu_mod_shift,
      note_en:      cpu_note_en,
      synth_shift:  cpu_synth_shift
   };

`ifdef SYNTH_PARAM_RX_SAMPLE_ALIGN_EN
   assign apply_ok = sample_tick;
`else
   logic unused_sample_tick;
   assign unused_sample_tick = sample_tick;
   assign apply_ok           = 1'b1;
`endif

   // Outputs are registered on the edge that enters APPLY, so the apply edge
   // is the one leaving CAPTURE. In the alignment build CAPTURE therefore
   // holds until sample_tick, which keeps the default latency at
   // SYNC_STAGES+1 edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         out_q    <= '0;
         update_q <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         update_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (req_s) begin
                  shadow_q <= cpu_bundle;
                  state_q  <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (apply_ok) begin
                  out_q    <= shadow_q;
                  update_q <= 1'b1;
                  ack_q    <= 1'b1;
                  state_q  <= APPLY;
               end
            end
            APPLY: begin
               state_q <= WAIT_LOW;
            end
            WAIT_LOW: begin
               if (!req_s) begin
                  ack_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ack_out      = ack_q;
   assign update       = update_q;
   assign carrier_fcws = out_q.carrier_fcws;
   assign mod_fcw      = out_q.mod_fcw;
   assign mod_shift    = out_q.mod_shift;
   assign note_en      = out_q.note_en;
   assign synth_shift  = out_q.synth_shift;

endmodule

// File: tb/tb_synth_param_rx.sv
// ----------------------------------------------------------------------------
// tb_synth_param_rx
// Directed bench for synth_param_rx with four voices: reset state, basic
// transfer latency, bus change after capture, short request pulse, reset
// mid-transfer and a run of back-to-back transfers.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_synth_param_rx;

   localparam int unsigned NV  = 4;
   localparam int unsigned FW  = 24;
   localparam int unsigned SW  = 5;
   localparam int unsigned BW  = NV*FW + FW + SW + NV + SW;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_in;
   logic [NV*FW-1:0]  cpu_carrier_fcws;
   logic [FW-1:0]     cpu_mod_fcw;
   logic [SW-1:0]     cpu_mod_shift;
   logic [NV-1:0]     cpu_note_en;
   logic [SW-1:0]     cpu_synth_shift;
   logic              sample_tick;
   logic              ack_out;
   logic [NV*FW-1:0]  carrier_fcws;
   logic [FW-1:0]     mod_fcw;
   logic [SW-1:0]     mod_shift;
   logic [NV-1:0]     note_en;
   logic [SW-1:0]     synth_shift;
   logic              update;

   int n_checks = 0;
   int n_fail   = 0;
   int upd_cnt  = 0;
   int exp_upd  = 0;
   int lat;

   synth_param_rx #(
      .N_VOICES    (NV),
      .FCW_W       (FW),
      .SHIFT_W     (SW),
      .SYNC_STAGES (2)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_in           (req_in),
      .cpu_carrier_fcws (cpu_carrier_fcws),
      .cpu_mod_fcw      (cpu_mod_fcw),
      .cpu_mod_shift    (cpu_mod_shift),
      .cpu_note_en      (cpu_note_en),
      .cpu_synth_shift  (cpu_synth_shift),
      .sample_tick      (sample_tick),
      .ack_out          (ack_out),
      .carrier_fcws     (carrier_fcws),
      .mod_fcw          (mod_fcw),
      .mod_shift        (mod_shift),
      .note_en          (note_en),
      .synth_shift      (synth_shift),
      .update           (update)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (update === 1'b1) upd_cnt++;

   initial begin
      sample_tick = 1'b0;
      forever begin
         repeat (9) @(posedge clk);
         #1 sample_tick = 1'b1;
         @(posedge clk);
         #1 sample_tick = 1'b0;
      end
   end

`ifdef SYNTH_PARAM_RX_SAMPLE_ALIGN_EN
   logic tick_seen = 1'b0;
   always @(posedge clk) tick_seen <= sample_tick;
`endif

   task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_update(input int max, output int steps);
      steps = 0;
      do begin
         step();
         steps++;
      end while (update !== 1'b1 && steps < max);
   endtask

   task automatic check_lat(input string tag, input int l);
`ifdef SYNTH_PARAM_RX_SAMPLE_ALIGN_EN
      check_eq(tag, 160'(l <= 14), 160'(1));
      check_eq({tag, "_tick"}, 160'(tick_seen), 160'(1));
`else
      check_eq(tag, 160'(l), 160'(4));
`endif
   endtask

   task automatic drop_req(input string tag);
      int n;
      req_in = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (ack_out !== 1'b0 && n < 10);
      check_eq(tag, 160'(ack_out), 160'(0));
   endtask

   function automatic logic [159:0] outs();
      return 160'({carrier_fcws, mod_fcw, mod_shift, note_en, synth_shift});
   endfunction

   initial begin
      logic [BW-1:0] exp_b;
      rst_n = 1'b0; req_in = 1'b0;
      cpu_carrier_fcws = '0; cpu_mod_fcw = '0; cpu_mod_shift = '0;
      cpu_note_en = '0; cpu_synth_shift = '0;
      repeat (3) step();
      check_eq("rst_ack",    160'(ack_out), 160'(0));
      check_eq("rst_update", 160'(update),  160'(0));
      check_eq("rst_outs",   outs(),        160'(0));
      rst_n = 1'b1;
      step();

      // basic transfer
      cpu_mod_fcw = 24'h123456; cpu_note_en = 4'b0001; req_in = 1'b1;
      wait_update(30, lat);
      exp_upd++;
      check_lat("basic_lat", lat);
      check_eq("basic_fcw",  160'(mod_fcw), 160'(24'h123456));
      check_eq("basic_note", 160'(note_en), 160'(4'b0001));
      check_eq("basic_ack",  160'(ack_out), 160'(1));

      // bus change after capture must not reach the outputs
      cpu_mod_fcw = 24'hABCDEF;
      repeat (4) step();
      check_eq("hold_fcw", 160'(mod_fcw), 160'(24'h123456));
      check_eq("hold_upd", 160'(upd_cnt), 160'(exp_upd));
      check_eq("hold_ack", 160'(ack_out), 160'(1));

      // ack falls SYNC_STAGES edges after the edge following the req drop
      req_in = 1'b0;
      repeat (2) step();
      check_eq("drop_ack_hi", 160'(ack_out), 160'(1));
      step();
      check_eq("drop_ack_lo", 160'(ack_out), 160'(0));

      // request pulse entirely between two edges
      step();
      #2 req_in = 1'b1;
      #2 req_in = 1'b0;
      repeat (8) step();
      check_eq("glitch_upd", 160'(upd_cnt), 160'(exp_upd));
      check_eq("glitch_ack", 160'(ack_out), 160'(0));

      // reset while in WAIT_LOW, release with req_in high
      cpu_mod_fcw = 24'h654321; cpu_note_en = 4'b1010; req_in = 1'b1;
      wait_update(30, lat);
      exp_upd++;
      check_eq("mid_fcw", 160'(mod_fcw), 160'(24'h654321));
      repeat (2) step();
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_ack",  160'(ack_out), 160'(0));
      check_eq("mid_rst_upd",  160'(update),  160'(0));
      check_eq("mid_rst_outs", outs(),        160'(0));
      cpu_mod_fcw = 24'h0F0F0F; cpu_note_en = 4'b0110;
      rst_n = 1'b1;
      wait_update(30, lat);
      exp_upd++;
      check_lat("recap_lat", lat);
      check_eq("recap_fcw",  160'(mod_fcw), 160'(24'h0F0F0F));
      check_eq("recap_note", 160'(note_en), 160'(4'b0110));
      drop_req("recap_drop");

      // back-to-back transfers
      for (int t = 0; t < 100; t++) begin
         for (int v = 0; v < int'(NV); v++)
            cpu_carrier_fcws[v*FW +: FW] = FW'($urandom);
         cpu_mod_fcw     = FW'($urandom);
         cpu_mod_shift   = SW'($urandom);
         cpu_note_en     = NV'($urandom);
         cpu_synth_shift = SW'($urandom);
         exp_b = {cpu_carrier_fcws, cpu_mod_fcw, cpu_mod_shift, cpu_note_en, cpu_synth_shift};
         req_in = 1'b1;
         wait_update(30, lat);
         exp_upd++;
         check_eq("b2b_outs", outs(), 160'(exp_b));
         drop_req("b2b_drop");
      end
      repeat (3) step();
      check_eq("b2b_upd_cnt", 160'(upd_cnt), 160'(exp_upd));
      check_eq("final_outs",  outs(),        160'(exp_b));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/synth_param_rx.md
# synth_param_rx

Synth-clock-domain (pwm_clk) end of the four-phase req/ack parameter handshake driven by the CPU-side CDC initiator. It synchronizes the CPU's request, captures the parameter bus into shadow registers, and presents the parameters as stable, glitch-free outputs to `synth` and `scaler`. It then returns a registered acknowledge to the CPU domain.

## Interface
- `N_VOICES`, default 1: number of carrier voices.
- `FCW_W`, default 24: frequency-control-word width.
- `SHIFT_W`, default 5: width of the `mod_shift` and `synth_shift` fields.
- `SYNC_STAGES`, default 2: flop depth of the `req_in` synchronizer; legal values are 2 and up.

Ports:
- `clk`  in  1: pwm_clk.
- `rst_n`  in  1: asynchronous reset, active-low.
- `req_in`  in  1: CPU-domain request; asynchronous to `clk`.
- `cpu_carrier_fcws`  in  N_VOICES*FCW_W: voice i occupies bits [i*FCW_W +: FCW_W].
- `cpu_mod_fcw`  in  FCW_W.
- `cpu_mod_shift`  in  SHIFT_W.
- `cpu_note_en`  in  N_VOICES.
- `cpu_synth_shift`  in  SHIFT_W.
- `sample_tick`  in  1: sample-boundary strobe from `sampler`; used only when the alignment feature is compiled in.
- `ack_out`  out  1: registered acknowledge back to the CPU domain.
- `carrier_fcws`, `mod_fcw`, `mod_shift`, `note_en`, `synth_shift`  out: widths match the `cpu_*` inputs; applied parameters.
- `update`  out  1: one-cycle pulse on the edge the outputs take new values.

## Operation
- The CPU holds all `cpu_*` buses stable from before `req_in` rises until `ack_out` is seen high. The block never samples the buses outside the CAPTURE transition.
- `req_in` passes through a SYNC_STAGES flop chain; the last stage is `req_s`.
- FSM states:
  - IDLE: `ack_out`=0. If `req_s`=1, go to CAPTURE.
  - CAPTURE: shadow registers load all `cpu_*` buses. Go to APPLY unconditionally.
  - APPLY: outputs load from shadow, `update`=1 for that edge, and `ack_out` is set. Go to WAIT_LOW.
  - WAIT_LOW: `ack_out` held at 1. If `req_s`=0, clear `ack_out` and go to IDLE.
- `ack_out` is a direct flop output with no combinational logic after it, so it is safe to synchronize in the CPU domain.
- Outputs change only on APPLY edges and hold their values otherwise.
- A `req_s` glitch-free rise while in WAIT_LOW is impossible by protocol. If `req_s` stays high, the FSM simply remains in WAIT_LOW.
- Reset, asynchronous and usable mid-transfer:
  - State returns to IDLE.
  - `ack_out`, `update`, all synchronizer flops, shadows and every parameter output go to 0; notes are disabled and FCWs are 0.
  - If `req_in` is still high after reset releases, a fresh transfer re-captures the buses. This is harmless because transfers are idempotent.

## Timing
- `req_in` rises before edge k: `req_s`=1 after edge k+SYNC_STAGES-1, capture at edge k+SYNC_STAGES, outputs/`update`/`ack_out` at edge k+SYNC_STAGES+1. With defaults, that is edge k+3.
- `req_in` falls before edge m (in WAIT_LOW): `ack_out`=0 after edge m+SYNC_STAGES. The earliest next capture is 2 edges after the next `req_s` rise.
- Minimum round trip is limited by the CPU-side synchronizer. The block accepts back-to-back transfers with no extra dead cycles beyond IDLE.

## Configuration
- `SYNTH_PARAM_RX_SAMPLE_ALIGN_EN` defined:
  - APPLY waits until `sample_tick`=1, then applies, pulses `update`, and raises `ack_out` on that edge.
  - A `sample_tick` asserted in IDLE, CAPTURE or WAIT_LOW is ignored.
  - Parameters therefore change only between samples.
- Undefined: APPLY is a single unconditional cycle and the `sample_tick` input is ignored. The port is still present.

## Structure
- Shared package `synth_pkg` holds:
  - FSM state enum: IDLE, CAPTURE, APPLY, WAIT_LOW.
  - Default width constants: FCW_W=24, SHIFT_W=5.
  - A packed parameter-bundle struct (carrier FCWs, mod FCW, mod shift, note_en, synth shift), so shadow and output registers are one assignment each.
- Sub-module: the existing `synchronizer`, made parameterizable in depth, instantiated for `req_in`. No other submodules.

## Test plan
- Basic transfer: reset, then set `cpu_mod_fcw`=24'h123456 and `note_en`=1, and raise `req_in`. Expect `update` and `mod_fcw`=24'h123456 3 edges later with `ack_out`=1. Drop `req_in`; expect `ack_out`=0 2 edges later.
- Bus change after capture: change `cpu_mod_fcw` to 24'hABCDEF one cycle after CAPTURE while `req_in` is still high. Outputs must keep 24'h123456, and there is no second `update`.
- Reset mid-transfer: assert `rst_n`=0 while in WAIT_LOW. Expect all outputs and `ack_out`=0 immediately. Release with `req_in` high; expect re-capture with outputs valid 3 edges after release.
- Back-to-back: run 100 random transfers with `N_VOICES`=4. Every transfer yields exactly one `update`, and the outputs equal the last captured bundle.
- Sample alignment (with the macro defined): `sample_tick` every 10 cycles. `update` and the `ack_out` rise must coincide with a `sample_tick` edge, and latency stays at or below 3+10 edges.
- Glitchy request: a 1-cycle `req_in` pulse shorter than the sync window and never seen by `req_s`. Expect no `update` and `ack_out` stays 0.
